// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM encoding,
// and the lane/byte-enable/extension helpers used by the top level.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Misaligned halves/words, reserved funct3 codes, and unsigned-store codes.
    function automatic logic f_illegal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] lane);
        case (funct3)
            F3_B:         f_illegal = 1'b0;
            F3_H:         f_illegal = lane[0];
            F3_W:         f_illegal = (lane != 2'b00);
            F3_BU, F3_HU: f_illegal = we;
            default:      f_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] f_byte_en(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b00:   f_byte_en = 4'b0001 << lane;
            2'b01:   f_byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: f_byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3[1:0])
            2'b00:   f_store_lanes = {4{wdata[7:0]}};
            2'b01:   f_store_lanes = {2{wdata[15:0]}};
            default: f_store_lanes = wdata;
        endcase
    endfunction

    function automatic logic [31:0] f_load_ext(input logic [2:0] funct3, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [31:0] w_shift;
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        w_shift = word >> {lane, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    f_load_ext = {{24{w_byte[7]}}, w_byte};
            F3_BU:   f_load_ext = {24'h000000, w_byte};
            F3_H:    f_load_ext = {{16{w_half[15]}}, w_half};
            F3_HU:   f_load_ext = {16'h0000, w_half};
            default: f_load_ext = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_byte_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked load/store responder: accept, optional wait states, one RAM access,
// then a held response until the core takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH_DATA  = 32,
    parameter int WIDTH_ADDR  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [WIDTH_ADDR-1:0] req_addr,
    input  logic [WIDTH_DATA-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH_DATA-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int                  AW         = $clog2(DEPTH_WORDS);
    localparam logic [WIDTH_ADDR:0] ADDR_LIMIT = (WIDTH_ADDR+1)'(DEPTH_WORDS * 4);
    localparam logic [3:0]          CNT_LAST   = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        r_we;
    logic        r_err;
    logic [2:0]  r_funct3;
    logic [AW+1:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_err_in;
    logic        w_ram_en;
    logic [31:0] w_ram_rdata;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_err_in  = f_illegal(req_we, req_funct3, req_addr[1:0]) ||
                       ({1'b0, req_addr} >= ADDR_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err_in)              w_state_nxt = ST_RESP;
                    else if (WAIT_CYCLES == 0) w_state_nxt = ST_ACCESS;
                    else                       w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT:   if (r_cnt == CNT_LAST) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   if (r_rsp_valid && rsp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)                r_cnt <= 4'd0;
            else if (r_state == ST_WAIT) r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we     <= req_we;
            r_err    <= w_err_in;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[AW+1:0];
            r_wdata  <= req_wdata;
        end
    end

    // RESP spends its first cycle formatting the registered RAM word, then holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == ST_RESP) begin
            if (!r_rsp_valid) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_err || r_we) ? 32'h0
                                               : f_load_ext(r_funct3, r_addr[1:0], w_ram_rdata);
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_rdata <= 32'h0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    assign w_ram_en = (r_state == ST_ACCESS) && !r_err;

    dmem_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .i_en   (w_ram_en),
        .i_we   (r_we),
        .i_be   (f_byte_en(r_funct3, r_addr[1:0])),
        .i_addr (r_addr[AW+1:2]),
        .i_wdata(f_store_lanes(r_funct3, r_wdata)),
        .o_rdata(w_ram_rdata)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES=1 and hand-computed expectations.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(
        .WIDTH_DATA (32),
        .WIDTH_ADDR (32),
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, scramble the inputs after accept, and take the response.
    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFC;
        req_wdata  = 32'h5555_5555;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xfer(we, f3, addr, wd, rd, er, lat);
        chk({tag, ".lat"}, 32'(lat), exp_err ? 32'd1 : 32'd3);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
        chk({tag, ".rdata"}, rd, exp_rd);
    endtask

    initial begin
        logic [31:0] held;
        int          guard;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        tick();
        tick();
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        chk("rst.rsp_err",   {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle.rsp_ready_ignored", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;

        op("sw_beef",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op("lw_beef",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        op("sw_zero",  1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);
        op("sb_80",    1'b1, 3'b000, 32'h13, 32'h0000_0080, 32'h0, 1'b0);
        op("lw_sb",    1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_0000, 1'b0);
        op("lb_13",    1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
        op("lbu_13",   1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0);

        op("sw_20",    1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        op("sh_8001",  1'b1, 3'b001, 32'h22, 32'hABCD_8001, 32'h0, 1'b0);
        op("lh_22",    1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
        op("lhu_22",   1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
        op("lw_20",    1'b0, 3'b010, 32'h20, 32'h0, 32'h8001_3344, 1'b0);
        op("sb_21",    1'b1, 3'b000, 32'h21, 32'h0000_005A, 32'h0, 1'b0);
        op("lw_20b",   1'b0, 3'b010, 32'h20, 32'h0, 32'h8001_5A44, 1'b0);
        op("lh_20",    1'b0, 3'b001, 32'h20, 32'h0, 32'h0000_5A44, 1'b0);

        op("sw_0",     1'b1, 3'b010, 32'h0, 32'hA5A5_A5A5, 32'h0, 1'b0);
        op("e_lw_11",  1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
        op("e_lh_13",  1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1);
        op("e_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        op("e_sw_oor", 1'b1, 3'b010, 32'h1000, 32'h0BAD_0BAD, 32'h0, 1'b1);
        op("e_sw_12",  1'b1, 3'b010, 32'h12, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op("e_sbu",    1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op("lw_0_kept",  1'b0, 3'b010, 32'h0,  32'h0, 32'hA5A5_A5A5, 1'b0);
        op("lw_10_kept", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_0000, 1'b0);

        // Response back-pressure: hold rsp_ready low for five cycles.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        tick();
        req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            tick();
            guard++;
        end
        chk("hold.lat", 32'(guard), 32'd3);
        held = rsp_rdata;
        chk("hold.rdata", held, 32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            tick();
            chk("hold.rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold.rdata_stable", rsp_rdata, 32'h8000_0000);
            chk("hold.req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("release.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("release.req_ready", {31'd0, req_ready}, 32'd1);

        // Reset in WAIT drops the pending store.
        op("sw_30_old", 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        req_wdata  = 32'h1234_5678;
        tick();
        req_valid = 1'b0;
        chk("wait.req_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst.rsp_rdata", rsp_rdata, 32'h0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        op("lw_30_old", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
